// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Collects a block of 17-bit partial sums from the upstream 16-bit adder
//   stage into one ACC_W-bit total. Each block has cfg_len beats (0 means 1),
//   and cfg_len is sampled on the block's first beat. The result is presented
//   with a valid/ready handshake.
//
//   The adder is one bit wider than the accumulator. A carry out of the top
//   accumulator bit sets a sticky overflow flag that stays set for the rest of
//   the block.
//
//   Optional build macro SUM_ACC_SAT_EN:
//     defined   -> after an overflow the accumulator saturates to all-ones and
//                  stays there until the block ends
//     undefined -> the accumulator wraps modulo 2^ACC_W
//   In both builds out_ovf reports the overflow.
module sum_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      in_sum,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [LEN_W:0]   len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             outValid_q, outValid_d;
  logic [ACC_W-1:0] outAcc_q, outAcc_d;
  logic             outOvf_q, outOvf_d;
  logic             busy_q, busy_d;

  logic             beatFire;
  logic [ACC_W:0]   sumWide;
  logic             carry;
  logic [ACC_W-1:0] accAdd;
  logic             ovfAdd;
  logic [LEN_W:0]   cntInc;
  logic [LEN_W:0]   lenFirst;

  // in_ready is combinational: it must drop in the same cycle that clear is
  // raised, so a beat offered alongside clear is never taken.
  assign in_ready = (state_q != HOLD) && !clear;
  assign beatFire = in_valid && in_ready;

  // Widen both operands by one bit so that the carry out of the top
  // accumulator bit shows up as sumWide[ACC_W].
  assign sumWide  = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
  assign carry    = sumWide[ACC_W];
  assign ovfAdd   = ovf_q || carry;
  assign cntInc   = cnt_q + {{LEN_W{1'b0}}, 1'b1};

  // A length of zero is treated as a one-beat block. The counter and the
  // length are one bit wider than cfg_len, so the largest length completes
  // without the counter wrapping.
  assign lenFirst = (cfg_len == '0) ? {{LEN_W{1'b0}}, 1'b1} : {1'b0, cfg_len};

  // Pick the accumulator value for an ACCUM beat: saturating or wrapping.
`ifdef SUM_ACC_SAT_EN
  always_comb begin
    accAdd = sumWide[ACC_W-1:0];
    if (ovfAdd) begin
      accAdd = '1;
    end
  end
`else
  always_comb begin
    accAdd = sumWide[ACC_W-1:0];
  end
`endif

  // Next-state and next-output logic. Every register holds by default, and
  // clear overrides everything else at the end.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    outValid_d = outValid_q;
    outAcc_d   = outAcc_q;
    outOvf_d   = outOvf_q;

    unique case (state_q)
      IDLE: begin
        if (beatFire) begin
          acc_d = ACC_W'(in_sum);
          cnt_d = {{LEN_W{1'b0}}, 1'b1};
          len_d = lenFirst;
          ovf_d = 1'b0;
          if (lenFirst == {{LEN_W{1'b0}}, 1'b1}) begin
            state_d    = HOLD;
            outValid_d = 1'b1;
            outAcc_d   = ACC_W'(in_sum);
            outOvf_d   = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (beatFire) begin
          acc_d = accAdd;
          cnt_d = cntInc;
          ovf_d = ovfAdd;
          if (cntInc == len_q) begin
            state_d    = HOLD;
            outValid_d = 1'b1;
            outAcc_d   = accAdd;
            outOvf_d   = ovfAdd;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d    = IDLE;
          outValid_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        outValid_d = 1'b0;
      end
    endcase

    if (clear) begin
      state_d    = IDLE;
      acc_d      = '0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      outValid_d = 1'b0;
      outAcc_d   = '0;
      outOvf_d   = 1'b0;
    end
  end

  // busy is registered. It follows the state that is about to be entered, so
  // it lines up exactly with the ACCUM and HOLD states.
  assign busy_d = (state_d != IDLE);

  // State and output registers, cleared immediately when rst_n goes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      outAcc_q   <= '0;
      outOvf_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
      outAcc_q   <= outAcc_d;
      outOvf_q   <= outOvf_d;
      busy_q     <= busy_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_acc   = outAcc_q;
  assign out_ovf   = outOvf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed testbench for sum_accumulator.
// The main instance uses ACC_W=24. A second instance with ACC_W=17 covers
// the overflow and wrap/saturate case. Build with SUM_ACC_SAT_EN defined to
// expect the saturating result.
module tb_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_sum;
  logic [7:0]  cfg_len;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_acc;
  logic        out_ovf;
  logic        busy;

  logic        v17;
  logic        ir17;
  logic [16:0] s17;
  logic [7:0]  len17;
  logic        clr17;
  logic        ov17;
  logic        rdy17;
  logic [16:0] acc17;
  logic        ovf17;
  logic        busy17;

  int checkCount;
  int passCount;

`ifdef SUM_ACC_SAT_EN
  localparam logic [16:0] EXP_OVF17 = 17'h1FFFF;
`else
  localparam logic [16:0] EXP_OVF17 = 17'h00001;
`endif

  sum_accumulator #(.ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .cfg_len(cfg_len), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );

  sum_accumulator #(.ACC_W(17), .LEN_W(8)) dut17 (
    .clk(clk), .rst_n(rst_n), .in_valid(v17), .in_ready(ir17),
    .in_sum(s17), .cfg_len(len17), .clear(clr17),
    .out_valid(ov17), .out_ready(rdy17), .out_acc(acc17),
    .out_ovf(ovf17), .busy(busy17)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offers one beat for exactly one edge, then returns at edge+1.
  task automatic sendBeat(input logic [16:0] s);
    in_valid = 1'b1;
    in_sum   = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Consumes the pending result with a one-cycle out_ready pulse.
  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_valid got %b exp 0", out_valid); else passCount++;
    checkCount++; if (out_acc !== 24'h0) $display("[TB] FAIL rst_acc got %h exp 000000", out_acc); else passCount++;
    checkCount++; if (out_ovf !== 1'b0) $display("[TB] FAIL rst_ovf got %b exp 0", out_ovf); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy got %b exp 0", busy); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready got %b exp 1", in_ready); else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL post_rst_busy got %b exp 0", busy); else passCount++;
  endtask

  task automatic test_basic_block();
    cfg_len = 8'd3;
    sendBeat(17'h1FFFE);
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy got %b exp 1", busy); else passCount++;
    sendBeat(17'h00001);
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_early_valid got %b exp 0", out_valid); else passCount++;
    sendBeat(17'h10000);
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL basic_valid got %b exp 1", out_valid); else passCount++;
    checkCount++; if (out_acc !== 24'h02FFFF) $display("[TB] FAIL basic_acc got %h exp 02ffff", out_acc); else passCount++;
    checkCount++; if (out_ovf !== 1'b0) $display("[TB] FAIL basic_ovf got %b exp 0", out_ovf); else passCount++;
    releaseResult();
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_drop_valid got %b exp 0", out_valid); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL basic_idle_busy got %b exp 0", busy); else passCount++;
  endtask

  task automatic test_len_zero();
    cfg_len = 8'd0;
    sendBeat(17'h12345);
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL len0_valid got %b exp 1", out_valid); else passCount++;
    checkCount++; if (out_acc !== 24'h012345) $display("[TB] FAIL len0_acc got %h exp 012345", out_acc); else passCount++;
    checkCount++; if (out_ovf !== 1'b0) $display("[TB] FAIL len0_ovf got %b exp 0", out_ovf); else passCount++;
    releaseResult();
  endtask

  task automatic test_overflow();
    len17 = 8'd2;
    v17   = 1'b1;
    s17   = 17'h1FFFF;
    @(posedge clk);
    #1;
    s17 = 17'h00002;
    @(posedge clk);
    #1;
    v17 = 1'b0;
    checkCount++; if (ov17 !== 1'b1) $display("[TB] FAIL ovf_valid got %b exp 1", ov17); else passCount++;
    checkCount++; if (acc17 !== EXP_OVF17) $display("[TB] FAIL ovf_acc got %h exp %h", acc17, EXP_OVF17); else passCount++;
    checkCount++; if (ovf17 !== 1'b1) $display("[TB] FAIL ovf_flag got %b exp 1", ovf17); else passCount++;
    rdy17 = 1'b1;
    @(posedge clk);
    #1;
    rdy17 = 1'b0;
    checkCount++; if (ov17 !== 1'b0) $display("[TB] FAIL ovf_drop_valid got %b exp 0", ov17); else passCount++;
  endtask

  task automatic test_hold_stall();
    cfg_len = 8'd1;
    sendBeat(17'h00ABC);
    in_valid  = 1'b1;
    in_sum    = 17'h11111;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready[%0d] got %b exp 0", i, in_ready); else passCount++;
      @(posedge clk);
      #1;
      checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL stall_valid[%0d] got %b exp 1", i, out_valid); else passCount++;
      checkCount++; if (out_acc !== 24'h000ABC) $display("[TB] FAIL stall_acc[%0d] got %h exp 000abc", i, out_acc); else passCount++;
      checkCount++; if (out_ovf !== 1'b0) $display("[TB] FAIL stall_ovf[%0d] got %b exp 0", i, out_ovf); else passCount++;
    end
    in_valid = 1'b0;
    releaseResult();
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL stall_drop_valid got %b exp 0", out_valid); else passCount++;
    sendBeat(17'h00005);
    checkCount++; if (out_acc !== 24'h000005) $display("[TB] FAIL stall_next_acc got %h exp 000005", out_acc); else passCount++;
    releaseResult();
  endtask

  task automatic test_clear();
    cfg_len = 8'd4;
    sendBeat(17'd1);
    sendBeat(17'd2);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 17'd100;
    #1;
    checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL clear_in_ready got %b exp 0", in_ready); else passCount++;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL clear_busy got %b exp 0", busy); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL clear_valid got %b exp 0", out_valid); else passCount++;
    cfg_len = 8'd2;
    sendBeat(17'd5);
    sendBeat(17'd7);
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL clear_new_valid got %b exp 1", out_valid); else passCount++;
    checkCount++; if (out_acc !== 24'd12) $display("[TB] FAIL clear_new_acc got %h exp 00000c", out_acc); else passCount++;
    releaseResult();
  endtask

  task automatic test_back_to_back();
    cfg_len = 8'd2;
    sendBeat(17'd1);
    sendBeat(17'd2);
    checkCount++; if (out_acc !== 24'd3) $display("[TB] FAIL b2b_acc1 got %h exp 000003", out_acc); else passCount++;
    cfg_len   = 8'd1;
    in_valid  = 1'b1;
    in_sum    = 17'd10;
    out_ready = 1'b1;
    #1;
    checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL b2b_hold_ready got %b exp 0", in_ready); else passCount++;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL b2b_gap_valid got %b exp 0", out_valid); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_idle_ready got %b exp 1", in_ready); else passCount++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL b2b_valid2 got %b exp 1", out_valid); else passCount++;
    checkCount++; if (out_acc !== 24'd10) $display("[TB] FAIL b2b_acc2 got %h exp 00000a", out_acc); else passCount++;
    releaseResult();
  endtask

  task automatic test_max_len();
    cfg_len = 8'd255;
    sendBeat(17'd1);
    cfg_len = 8'd2;
    for (int i = 0; i < 253; i++) begin
      sendBeat(17'd1);
    end
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL maxlen_early_valid got %b exp 0", out_valid); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL maxlen_busy got %b exp 1", busy); else passCount++;
    sendBeat(17'd1);
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL maxlen_valid got %b exp 1", out_valid); else passCount++;
    checkCount++; if (out_acc !== 24'h0000FF) $display("[TB] FAIL maxlen_acc got %h exp 0000ff", out_acc); else passCount++;
    releaseResult();
  endtask

  task automatic test_async_reset();
    cfg_len = 8'd4;
    sendBeat(17'd3);
    sendBeat(17'd4);
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL arst_busy got %b exp 0", busy); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL arst_valid got %b exp 0", out_valid); else passCount++;
    checkCount++; if (out_acc !== 24'h0) $display("[TB] FAIL arst_acc got %h exp 000000", out_acc); else passCount++;
    checkCount++; if (out_ovf !== 1'b0) $display("[TB] FAIL arst_ovf got %b exp 0", out_ovf); else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL arst_idle_busy got %b exp 0", busy); else passCount++;
    cfg_len = 8'd1;
    sendBeat(17'd9);
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL arst_new_valid got %b exp 1", out_valid); else passCount++;
    checkCount++; if (out_acc !== 24'd9) $display("[TB] FAIL arst_new_acc got %h exp 000009", out_acc); else passCount++;
    releaseResult();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sum     = '0;
    cfg_len    = '0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    v17        = 1'b0;
    s17        = '0;
    len17      = '0;
    clr17      = 1'b0;
    rdy17      = 1'b0;

    test_reset();
    test_basic_block();
    test_len_zero();
    test_overflow();
    test_hold_stall();
    test_clear();
    test_back_to_back();
    test_max_len();
    test_async_reset();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
